// File: rtl/fetch_align.sv
// Instruction fetch aligner: word fetches in, one 16/32-bit instruction per handshake out.
// Define FETCH_ALIGN_RVC_EN to build compressed-parcel and straddling-instruction support.
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_raw,
  output logic        inst_is_c,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

`ifdef FETCH_ALIGN_RVC_EN
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif

  typedef enum logic [2:0] {
    S_FETCH,
    S_READY,
    S_DISCARD
`ifdef FETCH_ALIGN_RVC_EN
    , S_SPAN,
    S_SPLIT
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] word_buf_q, word_buf_d;
  logic        word_valid_q, word_valid_d;
  logic        fetch_req_q, fetch_req_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_raw_q, inst_raw_d;
  logic        fire;

`ifdef FETCH_ALIGN_RVC_EN
  logic [15:0] half_buf_q, half_buf_d;
  logic        inst_is_c_q, inst_is_c_d;

  function automatic logic is_comp(input logic [1:0] lsbs);
    return lsbs != 2'b11;
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    word_buf_d   = word_buf_q;
    word_valid_d = word_valid_q;
`ifdef FETCH_ALIGN_RVC_EN
    half_buf_d   = half_buf_q;
`endif
    fire = inst_valid_q & inst_ready;

    case (state_q)
      S_FETCH: begin
        if (fetch_ack) begin
          word_buf_d   = fetch_data;
          word_valid_d = 1'b1;
          state_d      = S_READY;
        end
      end
      S_READY: begin
`ifdef FETCH_ALIGN_RVC_EN
        if (pc_q[1]) begin
          if (is_comp(word_buf_q[17:16])) begin
            if (fire) begin
              pc_d         = pc_q + 32'd2;
              word_valid_d = 1'b0;
              state_d      = S_FETCH;
            end
          end else begin
            half_buf_d = word_buf_q[31:16];
            state_d    = S_SPAN;
          end
        end else if (is_comp(word_buf_q[1:0])) begin
          if (fire) pc_d = pc_q + 32'd2;
        end else
`endif
        if (fire) begin
          pc_d         = pc_q + 32'd4;
          word_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end
`ifdef FETCH_ALIGN_RVC_EN
      S_SPAN: begin
        if (fetch_ack) begin
          word_buf_d = fetch_data;
          state_d    = S_SPLIT;
        end
      end
      S_SPLIT: begin
        if (fire) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_READY;
        end
      end
`endif
      S_DISCARD: begin
        if (fetch_ack) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Redirect overrides everything, including a same-cycle transfer.
    if (redirect) begin
      pc_d         = redirect_pc & PC_MASK;
      word_valid_d = 1'b0;
`ifdef FETCH_ALIGN_RVC_EN
      half_buf_d   = '0;
`endif
      state_d      = (fetch_req_q && !fetch_ack) ? S_DISCARD : S_FETCH;
    end
  end

  // Outputs are computed from the next state and registered.
  always_comb begin
    fetch_req_d  = (state_d == S_FETCH) || (state_d == S_DISCARD);
    fetch_addr_d = fetch_addr_q;
    inst_valid_d = 1'b0;
    inst_pc_d    = pc_d;
    inst_raw_d   = inst_raw_q;
`ifdef FETCH_ALIGN_RVC_EN
    inst_is_c_d  = 1'b0;
    if (state_d == S_SPAN) begin
      fetch_req_d  = 1'b1;
      fetch_addr_d = {pc_d[31:2] + 30'd1, 2'b00};
    end
`endif
    if (state_d == S_FETCH) fetch_addr_d = {pc_d[31:2], 2'b00};

    if (state_d == S_READY && word_valid_d) begin
`ifdef FETCH_ALIGN_RVC_EN
      if (pc_d[1]) begin
        if (is_comp(word_buf_d[17:16])) begin
          inst_valid_d = 1'b1;
          inst_raw_d   = {16'h0000, word_buf_d[31:16]};
          inst_is_c_d  = 1'b1;
        end
      end else if (is_comp(word_buf_d[1:0])) begin
        inst_valid_d = 1'b1;
        inst_raw_d   = {16'h0000, word_buf_d[15:0]};
        inst_is_c_d  = 1'b1;
      end else begin
        inst_valid_d = 1'b1;
        inst_raw_d   = word_buf_d;
      end
`else
      inst_valid_d = 1'b1;
      inst_raw_d   = word_buf_d;
`endif
    end
`ifdef FETCH_ALIGN_RVC_EN
    if (state_d == S_SPLIT) begin
      inst_valid_d = 1'b1;
      inst_raw_d   = {word_buf_d[15:0], half_buf_d};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC & PC_MASK;
      word_buf_q   <= '0;
      word_valid_q <= 1'b0;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      inst_valid_q <= 1'b0;
      inst_pc_q    <= RESET_PC & PC_MASK;
      inst_raw_q   <= '0;
`ifdef FETCH_ALIGN_RVC_EN
      half_buf_q   <= '0;
      inst_is_c_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      word_buf_q   <= word_buf_d;
      word_valid_q <= word_valid_d;
      fetch_req_q  <= fetch_req_d;
      fetch_addr_q <= fetch_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      inst_raw_q   <= inst_raw_d;
`ifdef FETCH_ALIGN_RVC_EN
      half_buf_q   <= half_buf_d;
      inst_is_c_q  <= inst_is_c_d;
`endif
    end
  end

  assign fetch_req  = fetch_req_q;
  assign fetch_addr = fetch_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst_pc    = inst_pc_q;
  assign inst_raw   = inst_raw_q;
`ifdef FETCH_ALIGN_RVC_EN
  assign inst_is_c  = inst_is_c_q;
`else
  assign inst_is_c  = 1'b0;
`endif

endmodule
